// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Contents: FSM state encoding, arbiter owner encoding, memory enable
// levels, the PC word increment and the all-zero word.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Owner of the last contested memory cycle.
  typedef enum logic {
    RR_FETCH = 1'b0,
    RR_DBG   = 1'b1
  } rr_owner_e;

  localparam logic InsEnable  = 1'b1;
  localparam logic InsDisable = 1'b0;

  localparam int unsigned WordInc  = 4;
  localparam int unsigned CntW     = 2;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage : if_fetch_ctrl_pkg

// File: rtl/if_fetch_fifo.sv
// Two-entry {inst,pc} buffer between the fetch port and ID.
// Entry 0 is always the head and drives head_inst/head_pc directly, so the
// head outputs are registered and keep their last value once the buffer
// drains. A flush empties the buffer and overrides push and pop.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push/push_inst/pc   write a fetched word (ignored when full)
//   pop                 drop the head (ignored when empty)
//   flush               discard every entry
//   head_inst/head_pc   current head (valid when !empty)
//   count/full/empty    occupancy
module if_fetch_fifo
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [INST_W-1:0] head_inst,
  output logic [ADDR_W-1:0] head_pc,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty
);

  logic [INST_W-1:0] tail_inst;
  logic [ADDR_W-1:0] tail_pc;

  assign full  = (count == CntW'(DEPTH));
  assign empty = (count == CntW'(0));

  // Shift-style storage: pop moves entry 1 into entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_inst <= '0;
      head_pc   <= '0;
      tail_inst <= '0;
      tail_pc   <= '0;
      count     <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (empty) begin
            head_inst <= push_inst;
            head_pc   <= push_pc;
            count     <= CntW'(1);
          end else if (!full) begin
            tail_inst <= push_inst;
            tail_pc   <= push_pc;
            count     <= CntW'(DEPTH);
          end
        end
        2'b01: begin
          if (!empty) begin
            if (full) begin
              head_inst <= tail_inst;
              head_pc   <= tail_pc;
            end
            count <= count - CntW'(1);
          end
        end
        2'b11: begin
          if (full) begin
            head_inst <= tail_inst;
            head_pc   <= tail_pc;
            tail_inst <= push_inst;
            tail_pc   <= push_pc;
          end else begin
            // One entry (replace head) or empty (pop is a no-op, push lands).
            head_inst <= push_inst;
            head_pc   <= push_pc;
            if (empty) count <= CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : if_fetch_fifo

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, applies redirects,
// arbitrates the single instruction-memory read port between fetch and a
// debug reader, and buffers fetched words for ID.
// Optional build macro: IF_FETCH_PERF_EN adds fetch/stall counters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   halt_req                 level; stop issuing fetches
//   redirect_valid/_pc       load new PC (word aligned) and flush buffer
//   ins_en/ins_addr/rdata    combinational instruction memory port
//   id_valid/ready/inst/pc   buffer head handshake to ID
//   dbg_req/addr/gnt/rdata   debug read port, data returned on grant
//   halted                   HALT with an empty buffer
//   perf_fetch_cnt/stall_cnt (IF_FETCH_PERF_EN only) saturating counters
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_en,
  output logic [ADDR_W-1:0] ins_addr,
  input  logic [INST_W-1:0] ins_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic [INST_W-1:0] dbg_rdata,
  output logic              halted
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  fetch_state_e      state, state_nxt;
  rr_owner_e         rr_last, rr_nxt;
  logic [ADDR_W-1:0] pc;
  logic              fetch_want, fetch_gnt, pop;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;

  assign pop        = id_valid && id_ready;
  assign fetch_want = (state == RUN) && !redirect_valid && (!fifo_full || pop);
  assign halted     = (state == HALT) && fifo_empty;

  // State, PC and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      rr_last <= RR_FETCH;
      pc      <= RESET_PC;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_nxt;
      if (redirect_valid)  pc <= redirect_pc & AlignMask;
      else if (fetch_gnt)  pc <= pc + ADDR_W'(WordInc);
    end
  end

  // Next state, arbitration and memory port drive.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_last;
    fetch_gnt = 1'b0;
    dbg_gnt   = 1'b0;
    ins_en    = InsDisable;
    ins_addr  = '0;
    dbg_rdata = '0;

    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt_req) state_nxt = HALT;
      HALT:    if (!halt_req) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase

    // Contested cycles go to whoever lost the previous contest.
    if (fetch_want && dbg_req) begin
      if (rr_last == RR_FETCH) begin
        dbg_gnt = 1'b1;
        rr_nxt  = RR_DBG;
      end else begin
        fetch_gnt = 1'b1;
        rr_nxt    = RR_FETCH;
      end
    end else if (fetch_want) begin
      fetch_gnt = 1'b1;
    end else if (dbg_req) begin
      dbg_gnt = 1'b1;
    end

    if (fetch_gnt) begin
      ins_en   = InsEnable;
      ins_addr = pc;
    end else if (dbg_gnt) begin
      ins_en    = InsEnable;
      ins_addr  = dbg_addr;
      dbg_rdata = ins_rdata;
    end
  end

  if_fetch_fifo #(
    .INST_W (INST_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fetch_gnt),
    .push_inst (ins_rdata),
    .push_pc   (pc),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_inst (id_inst),
    .head_pc   (id_pc),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign id_valid = (fifo_count != CntW'(0));

`ifdef IF_FETCH_PERF_EN
  // Saturating fetch-grant and RUN-stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= ZeroWord;
      perf_stall_cnt <= ZeroWord;
    end else begin
      if (fetch_gnt && (perf_fetch_cnt != ~ZeroWord))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state == RUN) && !fetch_want && !redirect_valid && (perf_stall_cnt != ~ZeroWord))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule : if_fetch_ctrl

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: sequencing, back-pressure, redirect,
// debug arbitration, halt/drain/resume, PC wrap and asynchronous reset.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_req, redirect_valid, id_ready, dbg_req;
  logic [31:0] redirect_pc, dbg_addr;
  logic        ins_en, id_valid, dbg_gnt, halted;
  logic [31:0] ins_addr, ins_rdata, id_inst, id_pc, dbg_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign ins_rdata = ins_en ? mem_word(ins_addr) : 32'h0;

  if_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_en         (ins_en),
    .ins_addr       (ins_addr),
    .ins_rdata      (ins_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_gnt        (dbg_gnt),
    .dbg_rdata      (dbg_rdata),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before checks.
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic hr, input logic dr, input logic [31:0] da);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    halt_req       = hr;
    dbg_req        = dr;
    dbg_addr       = da;
    #1;
  endtask

  initial begin
    rst = 1'b1; halt_req = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    id_ready = 1'b1; dbg_req = 1'b0; dbg_addr = '0;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_ins_en", {31'b0, ins_en}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);

    // BOOT cycle, then sequential fetch with ID always ready
    @(negedge clk); rst = 1'b0; #1;
    chk("boot_ins_en", {31'b0, ins_en}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("seq_ins_en", {31'b0, ins_en}, 32'd1);
      chk("seq_ins_addr", ins_addr, 32'(4 * k));
      if (k > 0) begin
        chk("seq_id_valid", {31'b0, id_valid}, 32'd1);
        chk("seq_id_pc", id_pc, 32'(4 * (k - 1)));
        chk("seq_id_inst", id_inst, mem_word(32'(4 * (k - 1))));
      end
    end

    // Redirect to 0 to restart, then hold ID off for five cycles
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir0_ins_en", {31'b0, ins_en}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("bp1_id_valid", {31'b0, id_valid}, 32'd0);
    chk("bp1_ins_addr", ins_addr, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("bp2_id_pc", id_pc, 32'h0);
    chk("bp2_ins_addr", ins_addr, 32'h4);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("bp_full_ins_en", {31'b0, ins_en}, 32'd0);
      chk("bp_full_id_pc", id_pc, 32'h0);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rdy_id_pc0", id_pc, 32'h0);
    chk("rdy_ins_addr8", ins_addr, 32'h8);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rdy_id_pc4", id_pc, 32'h4);
    chk("rdy_ins_addr12", ins_addr, 32'hC);

    // Redirect with buffer holding 8 and 12
    drive(1'b1, 32'h103, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_id_pc8", id_pc, 32'h8);
    chk("redir_ins_en", {31'b0, ins_en}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("flush_id_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_id_pc_hold", id_pc, 32'h8);
    chk("redir_ins_addr", ins_addr, 32'h100);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_id_pc", id_pc, 32'h100);
    chk("redir_id_inst", id_inst, mem_word(32'h100));
    chk("redir_ins_addr2", ins_addr, 32'h104);

    // Debug arbitration alternates with fetch; pc moves only on fetch grants
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40);
    chk("dbg1_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("dbg1_ins_addr", ins_addr, 32'h40);
    chk("dbg1_rdata", dbg_rdata, mem_word(32'h40));
    chk("dbg1_id_pc", id_pc, 32'h104);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h44);
    chk("dbg2_gnt", {31'b0, dbg_gnt}, 32'd0);
    chk("dbg2_ins_addr", ins_addr, 32'h108);
    chk("dbg2_id_valid", {31'b0, id_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h44);
    chk("dbg3_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("dbg3_ins_addr", ins_addr, 32'h44);
    chk("dbg3_rdata", dbg_rdata, mem_word(32'h44));
    chk("dbg3_id_pc", id_pc, 32'h108);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("dbg4_ins_addr", ins_addr, 32'h10C);
    chk("dbg4_rdata_idle", dbg_rdata, 32'h0);

    // Halt with two entries buffered: drain, then halted; debug still served
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("h0_ins_addr", ins_addr, 32'h110);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("h1_ins_en_full", {31'b0, ins_en}, 32'd0);
    chk("h1_halted", {31'b0, halted}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("h2_ins_en", {31'b0, ins_en}, 32'd0);
    chk("h2_id_pc", id_pc, 32'h10C);
    chk("h2_halted", {31'b0, halted}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("h3_id_pc", id_pc, 32'h110);
    chk("h3_id_valid", {31'b0, id_valid}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h80);
    chk("h4_halted", {31'b0, halted}, 32'd1);
    chk("h4_id_valid", {31'b0, id_valid}, 32'd0);
    chk("h4_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("h4_ins_addr", ins_addr, 32'h80);
    chk("h4_dbg_rdata", dbg_rdata, mem_word(32'h80));
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("h5_ins_en", {31'b0, ins_en}, 32'd0);
    chk("h5_halted", {31'b0, halted}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("resume_ins_en", {31'b0, ins_en}, 32'd1);
    chk("resume_ins_addr", ins_addr, 32'h114);

    // PC wrap from the top word; low redirect bits are ignored
    drive(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_redir_ins_en", {31'b0, ins_en}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_ins_addr_top", ins_addr, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_ins_addr_zero", ins_addr, 32'h0);
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a cycle
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk("arst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_id_pc", id_pc, 32'h0);
    chk("arst_id_inst", id_inst, 32'h0);
    chk("arst_ins_en", {31'b0, ins_en}, 32'd0);
    chk("arst_ins_addr", ins_addr, 32'h0);
    chk("arst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("arst_boot_ins_en", {31'b0, ins_en}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("arst_restart_addr", ins_addr, 32'h0);
    chk("arst_restart_en", {31'b0, ins_en}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_if_fetch_ctrl
